// File: rtl/spi_nor_flash_responder.sv
// SPI NOR flash responder (mode 0) backed by an internal byte memory; oversampled on interfaceClk.
// Optional FAST_READ (0Bh) support is enabled by defining SPI_RESP_FAST_READ_EN.
module spi_nor_flash_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned PAGE_W      = 8,
    parameter int unsigned PROG_CYCLES = 64,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
    input  logic       interfaceClk,
    input  logic       reset,
    input  logic       MCLK,
    input  logic       CS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic       busy,
    output logic       cmdStrobe,
    output logic [7:0] lastCmd
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(PROG_CYCLES + 1);
    localparam int unsigned SH_W  = (ADDR_W > 8) ? ADDR_W : 8;
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'd1 << PAGE_W) - 64'd1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_DUMMY    = 3'd3;
    localparam logic [2:0] ST_DATA_IN  = 3'd4;
    localparam logic [2:0] ST_DATA_OUT = 3'd5;
    localparam logic [2:0] ST_IGNORE   = 3'd6;

    localparam logic [2:0] OP_RDSR = 3'd0;
    localparam logic [2:0] OP_RDID = 3'd1;
    localparam logic [2:0] OP_READ = 3'd2;
    localparam logic [2:0] OP_PP   = 3'd3;
    localparam logic [2:0] OP_FAST = 3'd4;

    logic [2:0]        mclk_sync_q, mclk_sync_d, cs_sync_q, cs_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic [2:0]        state_q, state_d, op_q, op_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [SH_W-2:0]   sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        out_q, out_d, last_cmd_q, last_cmd_d;
    logic [2:0]        obit_q, obit_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [CNT_W-1:0]  prog_cnt_q, prog_cnt_d;
    logic              wel_q, wel_d, wip_q, wip_d, rst_armed_q, rst_armed_d;
    logic              pp_wrote_q, pp_wrote_d, miso_q, miso_d, cmd_strobe_q, cmd_strobe_d;

    // Bytes are stored complemented so the all-zero configuration state reads back as erased 8'hFF.
    logic [7:0]        mem_q [DEPTH];
    logic              mem_we;
    logic [7:0]        mem_wdata;

    logic              mclk_rise, mclk_fall, cs_fall, cs_rise;
    logic [SH_W-1:0]   sh_full;
    logic [7:0]        byte_in, status, id_byte;
    logic [ADDR_W-1:0] addr_in;

    assign mclk_rise = mclk_sync_q[1] & ~mclk_sync_q[2];
    assign mclk_fall = ~mclk_sync_q[1] & mclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign sh_full   = {sh_q, mosi_sync_q[1]};
    assign byte_in   = sh_full[7:0];
    assign addr_in   = sh_full[ADDR_W-1:0];
    assign status    = {6'b0, wel_q, wip_q};

    always_comb begin
        case (id_idx_q)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
    end

    always_comb begin
        mclk_sync_d  = {mclk_sync_q[1:0], MCLK};
        cs_sync_d    = {cs_sync_q[1:0], CS_n};
        mosi_sync_d  = {mosi_sync_q[0], MOSI};
        state_d      = state_q;
        op_d         = op_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        addr_d       = addr_q;
        out_d        = out_q;
        obit_d       = obit_q;
        id_idx_d     = id_idx_q;
        prog_cnt_d   = prog_cnt_q;
        wel_d        = wel_q;
        wip_d        = wip_q;
        rst_armed_d  = rst_armed_q;
        pp_wrote_d   = pp_wrote_q;
        miso_d       = miso_q;
        last_cmd_d   = last_cmd_q;
        cmd_strobe_d = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        if (wip_q) begin
            if (prog_cnt_q <= CNT_W'(1)) begin
                wip_d      = 1'b0;
                prog_cnt_d = '0;
            end else begin
                prog_cnt_d = prog_cnt_q - CNT_W'(1);
            end
        end

        if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            if (op_q == OP_PP && (state_q == ST_ADDR || state_q == ST_DATA_IN)) begin
                wel_d = 1'b0;
                if (pp_wrote_q) begin
                    wip_d      = 1'b1;
                    prog_cnt_d = CNT_W'(PROG_CYCLES);
                end
            end
        end else if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_CMD: if (mclk_rise) begin
                    sh_d      = sh_full[SH_W-2:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d    = '0;
                        cmd_strobe_d = 1'b1;
                        last_cmd_d   = byte_in;
                        rst_armed_d  = 1'b0;
                        pp_wrote_d   = 1'b0;
                        obit_d       = '0;
                        state_d      = ST_IGNORE;
                        if (!wip_q || byte_in == 8'h05 || byte_in == 8'h9F) begin
                            case (byte_in)
                                8'h66: rst_armed_d = 1'b1;
                                8'h99: if (rst_armed_q) begin
                                    wel_d      = 1'b0;
                                    wip_d      = 1'b0;
                                    prog_cnt_d = '0;
                                end
                                8'h06: wel_d = 1'b1;
                                8'h04: wel_d = 1'b0;
                                8'h05: begin
                                    op_d    = OP_RDSR;
                                    out_d   = status;
                                    state_d = ST_DATA_OUT;
                                end
                                8'h9F: begin
                                    op_d     = OP_RDID;
                                    out_d    = JEDEC_ID[23:16];
                                    id_idx_d = 2'd1;
                                    state_d  = ST_DATA_OUT;
                                end
                                8'h03: begin
                                    op_d    = OP_READ;
                                    state_d = ST_ADDR;
                                end
                                8'h02: if (wel_q) begin
                                    op_d    = OP_PP;
                                    state_d = ST_ADDR;
                                end
`ifdef SPI_RESP_FAST_READ_EN
                                8'h0B: begin
                                    op_d    = OP_FAST;
                                    state_d = ST_ADDR;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: if (mclk_rise) begin
                    sh_d      = sh_full[SH_W-2:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_in;
                        if (op_q == OP_PP) begin
                            state_d = ST_DATA_IN;
                        end else if (op_q == OP_FAST) begin
                            state_d = ST_DUMMY;
                        end else begin
                            out_d   = ~mem_q[addr_in];
                            addr_d  = addr_in + ADDR_W'(1);
                            state_d = ST_DATA_OUT;
                        end
                    end
                end
                ST_DUMMY: if (mclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        out_d     = ~mem_q[addr_q];
                        addr_d    = addr_q + ADDR_W'(1);
                        state_d   = ST_DATA_OUT;
                    end
                end
                ST_DATA_IN: if (mclk_rise) begin
                    sh_d      = sh_full[SH_W-2:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d  = '0;
                        mem_we     = 1'b1;
                        mem_wdata  = mem_q[addr_q] | ~byte_in;
                        addr_d     = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_W'(1)) & PAGE_MASK);
                        pp_wrote_d = 1'b1;
                    end
                end
                ST_DATA_OUT: if (mclk_fall) begin
                    miso_d = out_q[7];
                    if (obit_q == 3'd7) begin
                        obit_d = '0;
                        case (op_q)
                            OP_RDSR: out_d = status;
                            OP_RDID: begin
                                out_d = id_byte;
                                if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                            end
                            default: begin
                                out_d  = ~mem_q[addr_q];
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        endcase
                    end else begin
                        out_d  = {out_q[6:0], 1'b0};
                        obit_d = obit_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge interfaceClk or negedge reset) begin
        if (!reset) begin
            mclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            state_q      <= ST_IDLE;
            op_q         <= OP_RDSR;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            addr_q       <= '0;
            out_q        <= '0;
            obit_q       <= '0;
            id_idx_q     <= '0;
            prog_cnt_q   <= '0;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            rst_armed_q  <= 1'b0;
            pp_wrote_q   <= 1'b0;
            miso_q       <= 1'b0;
            last_cmd_q   <= '0;
            cmd_strobe_q <= 1'b0;
        end else begin
            mclk_sync_q  <= mclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            op_q         <= op_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_q         <= sh_d;
            addr_q       <= addr_d;
            out_q        <= out_d;
            obit_q       <= obit_d;
            id_idx_q     <= id_idx_d;
            prog_cnt_q   <= prog_cnt_d;
            wel_q        <= wel_d;
            wip_q        <= wip_d;
            rst_armed_q  <= rst_armed_d;
            pp_wrote_q   <= pp_wrote_d;
            miso_q       <= miso_d;
            last_cmd_q   <= last_cmd_d;
            cmd_strobe_q <= cmd_strobe_d;
        end
    end

    always_ff @(posedge interfaceClk) begin
        if (mem_we) mem_q[addr_q] <= mem_wdata;
    end

    assign MISO      = miso_q;
    assign busy      = wip_q;
    assign cmdStrobe = cmd_strobe_q;
    assign lastCmd   = last_cmd_q;
endmodule
